inpkt_rx_parser: RTL and testbench

// - Parses the byte stream read from input_fifo (8-bit, first-word-fall-through, PKT_COMM_CLK side) into packets.
// - Validates the header, forwards payload bytes to the application core with back-pressure, and validates the trailer.
// - Reports errors as a sticky status byte that feeds pkt_comm_status (VCR-readable, drives the global error stop).

---
 rtl/inpkt_rx_parser.sv | 227 ++++++++++++++++++++++
 tb/tb_inpkt_rx_parser.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inpkt_rx_parser.sv
// -----------------------------------------------------------------------------
// inpkt_rx_parser
// Parses the byte stream read from input_fifo (8-bit, first-word-fall-through)
// into packets: an 8-byte header is validated, the payload is passed straight
// through to the application with back-pressure, and (optionally) a 4-byte
// little-endian payload checksum trailer is checked. Errors accumulate in a
// sticky status byte; any error parks the parser until RST.
//
// Build option:
//   INPKT_DATA_CKSUM_EN  defined   -> 4-byte trailer (~sum32 of payload) is
//                                     expected and checked, status[5] is live.
//                        undefined -> no trailer, status[5]=0, pkt_ok=1.
//
// Ports:
//   CLK        in   1   PKT_COMM_CLK
//   RST        in   1   synchronous, active-high reset
//   din        in   8   input_fifo dout
//   empty      in   1   input_fifo empty
//   rd_en      out  1   input_fifo read strobe (never asserted while empty)
//   dout       out  8   payload byte to the application (0 when wr_en=0)
//   wr_en      out  1   payload byte valid
//   full       in   1   application cannot accept a byte this cycle
//   pkt_type   out  8   type of the current packet
//   pkt_id     out  16  id of the current packet
//   pkt_len    out  24  payload length of the current packet
//   pkt_start  out  1   one-cycle pulse, header accepted
//   pkt_done   out  1   one-cycle pulse, packet complete
//   pkt_ok     out  1   qualifies pkt_done (1 = trailer good)
//   status     out  8   sticky errors [0]ver [1]type [2]hdr_cksum [3]len0
//                       [4]len_ovf [5]data_cksum [7:6]=0
//
// States:
//   S_HDR   | collecting the 8 header bytes, checks run on the last one
//   S_DATA  | forwarding payload bytes, down-counter tracks remaining length
//   S_CKSUM | collecting the 4-byte trailer (checksum build only)
//   S_ERR   | error seen, nothing read or written until RST
// -----------------------------------------------------------------------------
module inpkt_rx_parser #(
  parameter logic [7:0] VERSION      = 8'd2,
  parameter int         PKT_TYPE_MAX = 7,
  parameter int         PKT_LEN_MSB  = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  din,
  input  logic        empty,
  output logic        rd_en,
  output logic [7:0]  dout,
  output logic        wr_en,
  input  logic        full,
  output logic [7:0]  pkt_type,
  output logic [15:0] pkt_id,
  output logic [23:0] pkt_len,
  output logic        pkt_start,
  output logic        pkt_done,
  output logic        pkt_ok,
  output logic [7:0]  status
);

  localparam logic [7:0]  TYPE_MAX = 8'(PKT_TYPE_MAX);
  localparam logic [23:0] LEN_MASK = 24'((64'd1 << (PKT_LEN_MSB + 1)) - 64'd1);

  typedef enum logic [1:0] {
    S_HDR   = 2'd0,
    S_DATA  = 2'd1,
    S_CKSUM = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic [55:0] hdr_q;
  logic [23:0] data_cnt_q;
  logic [7:0]  pkt_type_q;
  logic [15:0] pkt_id_q;
  logic [23:0] pkt_len_q;
  logic        pkt_start_q;
  logic        pkt_done_q;
  logic        pkt_ok_q;
  logic [4:0]  hdr_stat_q;

`ifdef INPKT_DATA_CKSUM_EN
  logic [31:0] sum_q;
  logic [23:0] tr_q;
  logic        dcs_err_q;
`endif

  // Header bytes 0..6 are shifted in from the top, so after seven bytes byte 0
  // sits in [7:0]; byte 7 (hcs) is still on din when the checks are evaluated.
  logic [7:0]  hdr_sum;
  logic [23:0] hdr_len;
  logic [4:0]  hdr_err;

  assign hdr_len = hdr_q[39:16];
  assign hdr_sum = hdr_q[7:0] + hdr_q[15:8] + hdr_q[23:16] + hdr_q[31:24] +
                   hdr_q[39:32] + hdr_q[47:40] + hdr_q[55:48];

  assign hdr_err[0] = (hdr_q[7:0] != VERSION);
  assign hdr_err[1] = (hdr_q[15:8] == 8'd0) || (hdr_q[15:8] > TYPE_MAX);
  assign hdr_err[2] = (din != ~hdr_sum);
  assign hdr_err[3] = (hdr_len == 24'd0);
  assign hdr_err[4] = |(hdr_len & ~LEN_MASK);

  // Reads are gated by RST so no FIFO byte is lost while reset is held.
  always_comb begin
    rd_en = 1'b0;
    if (!RST) begin
      case (state_q)
        S_HDR:   rd_en = !empty;
        S_DATA:  rd_en = !empty && !full;
`ifdef INPKT_DATA_CKSUM_EN
        S_CKSUM: rd_en = !empty;
`endif
        default: rd_en = 1'b0;
      endcase
    end
  end

  assign wr_en = (state_q == S_DATA) && rd_en;
  assign dout  = wr_en ? din : 8'h00;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_HDR;
      cnt_q       <= 3'd0;
      hdr_q       <= 56'd0;
      data_cnt_q  <= 24'd0;
      pkt_type_q  <= 8'd0;
      pkt_id_q    <= 16'd0;
      pkt_len_q   <= 24'd0;
      pkt_start_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_ok_q    <= 1'b0;
      hdr_stat_q  <= 5'd0;
`ifdef INPKT_DATA_CKSUM_EN
      sum_q       <= 32'd0;
      tr_q        <= 24'd0;
      dcs_err_q   <= 1'b0;
`endif
    end else begin
      pkt_start_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_ok_q    <= 1'b0;
      case (state_q)
        S_HDR: begin
          if (rd_en) begin
            if (cnt_q == 3'd7) begin
              cnt_q <= 3'd0;
              if (hdr_err == 5'd0) begin
                state_q     <= S_DATA;
                pkt_start_q <= 1'b1;
                pkt_type_q  <= hdr_q[15:8];
                pkt_id_q    <= hdr_q[55:40];
                pkt_len_q   <= hdr_len;
                data_cnt_q  <= hdr_len;
`ifdef INPKT_DATA_CKSUM_EN
                sum_q       <= 32'd0;
`endif
              end else begin
                state_q    <= S_ERR;
                hdr_stat_q <= hdr_stat_q | hdr_err;
              end
            end else begin
              cnt_q <= cnt_q + 3'd1;
              hdr_q <= {din, hdr_q[55:8]};
            end
          end
        end
        S_DATA: begin
          if (rd_en) begin
            data_cnt_q <= data_cnt_q - 24'd1;
`ifdef INPKT_DATA_CKSUM_EN
            sum_q <= sum_q + {24'd0, din};
            if (data_cnt_q == 24'd1) state_q <= S_CKSUM;
`else
            if (data_cnt_q == 24'd1) begin
              state_q    <= S_HDR;
              pkt_done_q <= 1'b1;
              pkt_ok_q   <= 1'b1;
            end
`endif
          end
        end
`ifdef INPKT_DATA_CKSUM_EN
        S_CKSUM: begin
          if (rd_en) begin
            if (cnt_q == 3'd3) begin
              cnt_q      <= 3'd0;
              pkt_done_q <= 1'b1;
              if ({din, tr_q} == ~sum_q) begin
                pkt_ok_q <= 1'b1;
                state_q  <= S_HDR;
              end else begin
                dcs_err_q <= 1'b1;
                state_q   <= S_ERR;
              end
            end else begin
              cnt_q <= cnt_q + 3'd1;
              tr_q  <= {din, tr_q[23:8]};
            end
          end
        end
`endif
        S_ERR: begin
          state_q <= S_ERR;
        end
        default: begin
          state_q <= S_HDR;
        end
      endcase
    end
  end

  assign pkt_type  = pkt_type_q;
  assign pkt_id    = pkt_id_q;
  assign pkt_len   = pkt_len_q;
  assign pkt_start = pkt_start_q;
  assign pkt_done  = pkt_done_q;
  assign pkt_ok    = pkt_ok_q;

`ifdef INPKT_DATA_CKSUM_EN
  assign status = {2'b00, dcs_err_q, hdr_stat_q};
`else
  assign status = {3'b000, hdr_stat_q};
`endif

endmodule

// File: tb/tb_inpkt_rx_parser.sv
module tb_inpkt_rx_parser;

  typedef logic [7:0] u8;
  typedef struct packed {
    logic [7:0]  t;
    logic [15:0] id;
    logic [23:0] len;
  } sinfo_t;
  typedef struct {
    u8           ver;
    u8           typ;
    logic [23:0] len;
    u8           hcs_adj;
    u8           exp_status;
    int          exp_starts;
  } hvec_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  din = 8'h00;
  logic        empty = 1'b1;
  logic        full = 1'b0;
  logic        rd_en, wr_en, pkt_start, pkt_done, pkt_ok;
  logic [7:0]  dout, pkt_type, status;
  logic [15:0] pkt_id;
  logic [23:0] pkt_len;

  inpkt_rx_parser dut (
    .CLK(CLK), .RST(RST), .din(din), .empty(empty), .rd_en(rd_en),
    .dout(dout), .wr_en(wr_en), .full(full), .pkt_type(pkt_type),
    .pkt_id(pkt_id), .pkt_len(pkt_len), .pkt_start(pkt_start),
    .pkt_done(pkt_done), .pkt_ok(pkt_ok), .status(status)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // stimulus / observation state
  u8      src_q[$];
  u8      stream[$];
  u8      pl[$];
  u8      wr_log[$];
  sinfo_t start_log[$];
  bit     done_log[$];
  int     cyc = 0, first_rd, last_rd, consumed, wr_total;
  int     rd_viol, wr_viol, start_tviol, done_tviol;
  int     gap_mode, full_mode, full_left;
  bit     full_trig, last_step_rd;

  // reference model results
  u8      m_wr[$];
  sinfo_t m_start[$];
  bit     m_done[$];
  u8      m_status;
  int     m_consumed;

  hvec_t  tv[9];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_b(input u8 b);
    src_q.push_back(b);
    stream.push_back(b);
  endtask

  // Header + payload from pl (+ trailer in the checksum build).
  task automatic push_pkt(input u8 ver, input u8 typ, input logic [23:0] len,
                          input logic [15:0] id, input u8 hcs_adj, input bit bad_tr);
    u8 h[8];
    u8 hs;
    logic [31:0] ds;
    h = '{ver, typ, len[7:0], len[15:8], len[23:16], id[7:0], id[15:8], 8'h00};
    hs = 8'h00;
    for (int i = 0; i < 7; i++) hs = hs + h[i];
    h[7] = ~hs + hcs_adj;
    for (int i = 0; i < 8; i++) push_b(h[i]);
    ds = 32'd0;
    foreach (pl[i]) begin
      push_b(pl[i]);
      ds = ds + 32'(pl[i]);
    end
    ds = bad_tr ? 32'd0 : ~ds;
`ifdef INPKT_DATA_CKSUM_EN
    for (int k = 0; k < 4; k++) push_b(ds[8*k +: 8]);
`endif
  endtask

  // Packet-level model: walks the byte stream sent since the last reset.
  task automatic model_run();
    int p;
    u8 h[8];
    u8 hs;
    u8 st;
    logic [23:0] ln;
    sinfo_t si;
`ifdef INPKT_DATA_CKSUM_EN
    logic [31:0] ds, tr;
`endif
    m_wr.delete(); m_start.delete(); m_done.delete();
    m_status = 8'h00;
    m_consumed = -1;
    p = 0;
    while (p + 8 <= stream.size() && m_consumed < 0) begin
      for (int i = 0; i < 8; i++) h[i] = stream[p+i];
      p += 8;
      hs = 8'h00;
      for (int i = 0; i < 7; i++) hs = hs + h[i];
      ln = {h[4], h[3], h[2]};
      st = 8'h00;
      st[0] = (h[0] != 8'd2);
      st[1] = (h[1] == 8'd0) || (h[1] > 8'd7);
      st[2] = (h[7] != u8'(~hs));
      st[3] = (ln == 24'd0);
      st[4] = (ln > 24'h01FFFF);
      if (st != 8'h00) begin
        m_status = m_status | st;
        m_consumed = p;
      end else begin
        si.t = h[1]; si.id = {h[6], h[5]}; si.len = ln;
        m_start.push_back(si);
`ifdef INPKT_DATA_CKSUM_EN
        ds = 32'd0;
`endif
        for (int k = 0; k < int'(ln); k++) begin
          m_wr.push_back(stream[p+k]);
`ifdef INPKT_DATA_CKSUM_EN
          ds = ds + 32'(stream[p+k]);
`endif
        end
        p += int'(ln);
`ifdef INPKT_DATA_CKSUM_EN
        tr = {stream[p+3], stream[p+2], stream[p+1], stream[p]};
        p += 4;
        if (tr == ~ds) m_done.push_back(1'b1);
        else begin
          m_done.push_back(1'b0);
          m_status[5] = 1'b1;
          m_consumed = p;
        end
`else
        m_done.push_back(1'b1);
`endif
      end
    end
    if (m_consumed < 0) m_consumed = stream.size();
  endtask

  task automatic step();
    bit gap;
    @(negedge CLK);
    full = 1'b0;
    if (full_mode == 1) begin
      if (!full_trig && wr_total >= 2) begin
        full_trig = 1'b1;
        full_left = 5;
      end
      if (full_left > 0) begin
        full = 1'b1;
        full_left--;
      end
    end else if (full_mode == 2) begin
      full = ($urandom_range(0, 3) == 0);
    end
    if (gap_mode == 1)      gap = cyc[0];
    else if (gap_mode == 2) gap = ($urandom_range(0, 3) == 0);
    else                    gap = 1'b0;
    empty = (src_q.size() == 0) || gap;
    din = empty ? 8'($urandom) : src_q[0];
    #1;
    if (rd_en && empty) rd_viol++;
    if (wr_en && full) wr_viol++;
    if (wr_en) begin
      wr_log.push_back(dout);
      wr_total++;
    end
    if (pkt_start) begin
      sinfo_t si;
      si.t = pkt_type; si.id = pkt_id; si.len = pkt_len;
      start_log.push_back(si);
      if (last_rd != cyc - 1) start_tviol++;
    end
    if (pkt_done) begin
      done_log.push_back(pkt_ok);
      if (last_rd != cyc - 1) done_tviol++;
    end
    last_step_rd = rd_en;
    if (rd_en) begin
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
      consumed++;
      if (src_q.size() > 0) void'(src_q.pop_front());
    end
    cyc++;
  endtask

  task automatic reset_dut();
    @(negedge CLK);
    RST = 1'b1; empty = 1'b0; full = 1'b0; din = 8'hA5;
    @(negedge CLK);
    #1;
    chk("reset ctrl", longint'({rd_en, wr_en, pkt_start, pkt_done, pkt_ok, dout, status}), 0);
    chk("reset fields", longint'({pkt_type, pkt_id, pkt_len}), 0);
    @(negedge CLK);
    RST = 1'b0; empty = 1'b1;
    src_q.delete(); stream.delete(); pl.delete();
    wr_log.delete(); start_log.delete(); done_log.delete();
    first_rd = -1; last_rd = -100; consumed = 0; wr_total = 0;
    rd_viol = 0; wr_viol = 0; start_tviol = 0; done_tviol = 0;
    gap_mode = 0; full_mode = 0; full_left = 0; full_trig = 1'b0;
  endtask

  task automatic run_until_idle(input int max_cyc);
    int n, idle;
    n = 0; idle = 0;
    while (n < max_cyc && !(src_q.size() == 0 && idle >= 4) && idle < 40) begin
      step();
      n++;
      if (last_step_rd) idle = 0;
      else idle++;
    end
    if (n >= max_cyc) begin
      checks++; errors++;
      $display("FAIL timeout: ran %0d cycles, %0d bytes left", n, src_q.size());
    end
  endtask

  task automatic compare_all(input string tag);
    model_run();
    chk({tag, " wr_count"}, longint'(wr_log.size()), longint'(m_wr.size()));
    for (int i = 0; i < wr_log.size() && i < m_wr.size(); i++)
      chk($sformatf("%s dout[%0d]", tag, i), longint'(wr_log[i]), longint'(m_wr[i]));
    chk({tag, " start_count"}, longint'(start_log.size()), longint'(m_start.size()));
    for (int i = 0; i < start_log.size() && i < m_start.size(); i++)
      chk($sformatf("%s start[%0d] type/id/len", tag, i), longint'(start_log[i]), longint'(m_start[i]));
    chk({tag, " done_count"}, longint'(done_log.size()), longint'(m_done.size()));
    for (int i = 0; i < done_log.size() && i < m_done.size(); i++)
      chk($sformatf("%s pkt_ok[%0d]", tag, i), longint'(done_log[i]), longint'(m_done[i]));
    chk({tag, " status"}, longint'(status), longint'(m_status));
    chk({tag, " consumed"}, longint'(consumed), longint'(m_consumed));
    chk({tag, " rd_en while empty"}, longint'(rd_viol), 0);
    chk({tag, " wr_en while full"}, longint'(wr_viol), 0);
    chk({tag, " pkt_start timing"}, longint'(start_tviol), 0);
    chk({tag, " pkt_done timing"}, longint'(done_tviol), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    u8 exp_pl[4];
    u8 ver, typ, adj;
    bit bt;
    int np, ln;

    tv[0] = '{8'd2, 8'd1,   24'd3,       8'd0, 8'h00, 1};
    tv[1] = '{8'd3, 8'd1,   24'd3,       8'd0, 8'h01, 0};
    tv[2] = '{8'd2, 8'd1,   24'd3,       8'd1, 8'h04, 0};
    tv[3] = '{8'd2, 8'd0,   24'd0,       8'd0, 8'h0A, 0};
    tv[4] = '{8'd2, 8'd8,   24'd2,       8'd0, 8'h02, 0};
    tv[5] = '{8'd2, 8'd7,   24'h020000,  8'd0, 8'h10, 0};
    tv[6] = '{8'd1, 8'd9,   24'd5,       8'd1, 8'h07, 0};
    tv[7] = '{8'd2, 8'd7,   24'd2,       8'd0, 8'h00, 1};
    tv[8] = '{8'd2, 8'd255, 24'd1,       8'd0, 8'h02, 0};
    exp_pl = '{8'h11, 8'h22, 8'h33, 8'h44};

    // header checks from the vector table
    foreach (tv[i]) begin
      reset_dut();
      if (tv[i].exp_starts != 0)
        for (int k = 0; k < int'(tv[i].len); k++) pl.push_back(8'($urandom));
      push_pkt(tv[i].ver, tv[i].typ, tv[i].len, 16'($urandom), tv[i].hcs_adj, 1'b0);
      for (int k = 0; k < 3; k++) push_b(8'($urandom));
      run_until_idle(2000);
      chk($sformatf("tv%0d status", i), longint'(status), longint'(tv[i].exp_status));
      chk($sformatf("tv%0d starts", i), longint'(start_log.size()), longint'(tv[i].exp_starts));
      compare_all($sformatf("tv%0d", i));
    end

    // clean packet, then the same packet with stalls on both sides
    for (int mode = 0; mode < 2; mode++) begin
      reset_dut();
      gap_mode = mode; full_mode = mode;
      foreach (exp_pl[k]) pl.push_back(exp_pl[k]);
      push_pkt(8'd2, 8'd1, 24'd4, 16'h1234, 8'd0, 1'b0);
      run_until_idle(500);
      chk($sformatf("clean%0d wr_count", mode), longint'(wr_log.size()), 4);
      for (int k = 0; k < 4 && k < wr_log.size(); k++)
        chk($sformatf("clean%0d dout[%0d]", mode, k), longint'(wr_log[k]), longint'(exp_pl[k]));
      chk($sformatf("clean%0d starts", mode), longint'(start_log.size()), 1);
      if (start_log.size() > 0)
        chk($sformatf("clean%0d pkt_id", mode), longint'(start_log[0].id), 16'h1234);
      chk($sformatf("clean%0d dones", mode), longint'(done_log.size()), 1);
      if (done_log.size() > 0)
        chk($sformatf("clean%0d pkt_ok", mode), longint'(done_log[0]), 1);
      chk($sformatf("clean%0d status", mode), longint'(status), 0);
      compare_all($sformatf("clean%0d", mode));
    end

    // bad version parks the parser; RST recovers it
    reset_dut();
    foreach (exp_pl[k]) pl.push_back(exp_pl[k]);
    push_pkt(8'd3, 8'd1, 24'd4, 16'h1234, 8'd0, 1'b0);
    run_until_idle(500);
    chk("ver3 status", longint'(status), 8'h01);
    chk("ver3 starts", longint'(start_log.size()), 0);
    chk("ver3 wr_count", longint'(wr_log.size()), 0);
    chk("ver3 consumed", longint'(consumed), 8);
    reset_dut();
    foreach (exp_pl[k]) pl.push_back(exp_pl[k]);
    push_pkt(8'd2, 8'd1, 24'd4, 16'h1234, 8'd0, 1'b0);
    run_until_idle(500);
    chk("ver3 recover starts", longint'(start_log.size()), 1);
    compare_all("ver3 recover");

    // RST in the middle of a header
    reset_dut();
    for (int k = 0; k < 6; k++) pl.push_back(8'($urandom));
    push_pkt(8'd2, 8'd3, 24'd6, 16'hBEEF, 8'd0, 1'b0);
    for (int k = 0; k < 4; k++) step();
    reset_dut();
    pl.push_back(8'h5A); pl.push_back(8'hC3);
    push_pkt(8'd2, 8'd4, 24'd2, 16'h0F0F, 8'd0, 1'b0);
    run_until_idle(500);
    chk("midrst starts", longint'(start_log.size()), 1);
    compare_all("midrst");

`ifdef INPKT_DATA_CKSUM_EN
    // zero trailer on the clean payload
    reset_dut();
    foreach (exp_pl[k]) pl.push_back(exp_pl[k]);
    push_pkt(8'd2, 8'd1, 24'd4, 16'h1234, 8'd0, 1'b1);
    pl.delete();
    pl.push_back(8'h77);
    push_pkt(8'd2, 8'd1, 24'd1, 16'h0001, 8'd0, 1'b0);
    run_until_idle(500);
    chk("badtr dones", longint'(done_log.size()), 1);
    if (done_log.size() > 0) chk("badtr pkt_ok", longint'(done_log[0]), 0);
    chk("badtr status", longint'(status), 8'h20);
    chk("badtr consumed", longint'(consumed), 16);
    compare_all("badtr");
`endif

    // back-to-back len=1 packets, no gaps anywhere
    reset_dut();
    pl.push_back(8'hE1);
    push_pkt(8'd2, 8'd2, 24'd1, 16'hAAAA, 8'd0, 1'b0);
    pl.delete();
    pl.push_back(8'hE2);
    push_pkt(8'd2, 8'd6, 24'd1, 16'h5555, 8'd0, 1'b0);
    run_until_idle(500);
    chk("b2b starts", longint'(start_log.size()), 2);
    chk("b2b dones", longint'(done_log.size()), 2);
    chk("b2b read span", longint'(last_rd - first_rd + 1), longint'(stream.size()));
    compare_all("b2b");

    // random packets, random gaps and back-pressure, occasional errors
    for (int r = 0; r < 25; r++) begin
      reset_dut();
      gap_mode = 2; full_mode = 2;
      np = $urandom_range(1, 4);
      for (int n = 0; n < np; n++) begin
        ln = $urandom_range(1, 20);
        pl.delete();
        for (int k = 0; k < ln; k++) pl.push_back(8'($urandom));
        ver = 8'd2; typ = 8'($urandom_range(1, 7)); adj = 8'd0; bt = 1'b0;
        case ($urandom_range(0, 9))
          0: ver = 8'($urandom_range(0, 255));
          1: typ = 8'($urandom_range(0, 255));
          2: adj = 8'($urandom_range(1, 255));
          3: bt = 1'b1;
          default: ;
        endcase
        push_pkt(ver, typ, 24'(ln), 16'($urandom), adj, bt);
      end
      run_until_idle(4000);
      compare_all($sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
